// File: rtl/timer_apb_sched.sv
// timer_apb_sched: round-robin two-requester APB master for the timer.
// Ports: r0_*/r1_* commands, rsp_* tagged responses, m_p* APB master.
// Optional macro APB_TIMEOUT_EN bounds ACCESS waits to TIMEOUT_CYC.
`timescale 1ns/1ps
module timer_apb_sched #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic        r0_write,
  input  logic [11:0] r0_addr,
  input  logic [31:0] r0_wdata,
  input  logic [3:0]  r0_strb,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic        r1_write,
  input  logic [11:0] r1_addr,
  input  logic [31:0] r1_wdata,
  input  logic [3:0]  r1_strb,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [11:0] m_paddr,
  output logic        m_psel,
  output logic        m_penable,
  output logic        m_pwrite,
  output logic [31:0] m_pwdata,
  output logic [3:0]  m_pstrb,
  input  logic [31:0] m_prdata,
  input  logic        m_pready,
  input  logic        m_pslverr
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t state;
  logic   last_grant;
  logic   cur_id;
  logic   pick0;
  logic   pick1;
  logic   grant;
  logic   tmo;
  logic   done;

`ifdef APB_TIMEOUT_EN
  logic [7:0] acc_cnt;
`endif

  // On a tie, the requester not granted last wins.
  always_comb begin
    pick0 = r0_valid & (~r1_valid | last_grant);
    pick1 = r1_valid & ~pick0;
    grant = (state == IDLE) & (pick0 | pick1);
  end

  // Gated by reset so ready stays low while reset is held.
  assign r0_ready = sys_rst_n & (state == IDLE) & pick0;
  assign r1_ready = sys_rst_n & (state == IDLE) & pick1;

`ifdef APB_TIMEOUT_EN
  // acc_cnt counts prior waiting cycles; this is the last allowed one.
  assign tmo = ~m_pready
             & (acc_cnt == 8'(TIMEOUT_CYC - 1));
`else
  assign tmo = 1'b0;
`endif

  assign done = m_pready | tmo;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cur_id     <= 1'b0;
      m_paddr    <= '0;
      m_psel     <= 1'b0;
      m_penable  <= 1'b0;
      m_pwrite   <= 1'b0;
      m_pwdata   <= '0;
      m_pstrb    <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
`ifdef APB_TIMEOUT_EN
      acc_cnt    <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant) begin
            last_grant <= pick1;
            cur_id     <= pick1;
            m_paddr    <= pick1 ? r1_addr  : r0_addr;
            m_pwrite   <= pick1 ? r1_write : r0_write;
            m_pwdata   <= pick1 ? r1_wdata : r0_wdata;
            m_pstrb    <= pick1 ? r1_strb  : r0_strb;
            m_psel     <= 1'b1;
            state      <= SETUP;
`ifdef APB_TIMEOUT_EN
            acc_cnt    <= '0;
`endif
          end
        end
        SETUP: begin
          m_penable <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (done) begin
            m_psel    <= 1'b0;
            m_penable <= 1'b0;
            state     <= IDLE;
            rsp_valid <= 1'b1;
            rsp_id    <= cur_id;
            // A timeout (no pready) reports as an error.
            rsp_err   <= ~m_pready | m_pslverr;
            rsp_rdata <= (m_pready & ~m_pwrite & ~m_pslverr)
                       ? m_prdata : '0;
          end
`ifdef APB_TIMEOUT_EN
          else begin
            acc_cnt <= acc_cnt + 8'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
